// File: rtl/aes_key_expander.sv
// AES key-schedule engine for AES-128/192/256.
// Emits the expanded key w[0..TOTAL-1] as a valid/ready word stream, one word
// per cycle. Round constants come from an xtime register. SubWord uses an
// external combinational S-box bank, which is shared with the cipher datapath.
module aes_key_expander #(
    parameter int BYTE = 8,
    parameter int WORD = 32,
    parameter int NK   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [255:0]     key_in,
    output logic [WORD-1:0]  w_out,
    output logic [5:0]       w_idx,
    output logic             w_valid,
    input  logic             w_ready,
    output logic             busy,
    output logic             done,
    output logic [WORD-1:0]  sub_in,
    input  logic [WORD-1:0]  sub_out
);

    localparam int NR    = NK + 6;
    localparam int TOTAL = 4 * (NR + 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]      state_q, state_d;
    logic [WORD-1:0] win_q [NK];
    logic [WORD-1:0] win_d [NK];
    logic [5:0]      idx_q, idx_d;
    logic [2:0]      pos_q, pos_d;
    logic [BYTE-1:0] rcon_q, rcon_d;
    logic            done_q, done_d;

    logic [WORD-1:0] prev_word;
    logic [WORD-1:0] oldest_word;
    logic [WORD-1:0] temp_word;
    logic [WORD-1:0] word_now;
    logic [WORD-1:0] sub_word_in;
    logic            in_key;
    logic            do_rot;
    logic            do_sub_only;
    logic            running;
    logic            fire;

    // Key bits beyond the NK-word key are intentionally ignored.
    if (NK < 8) begin : g_key_tail
        logic key_unused;
        assign key_unused = ^key_in[255-WORD*NK:0];
    end

    // The window rotates during the key words. After NK accepts it holds
    // w[0..NK-1], so slot 0 is always w[i-NK] and slot NK-1 is always w[i-1].
    always_comb begin
        prev_word   = win_q[NK-1];
        oldest_word = win_q[0];
        in_key      = (idx_q < 6'(NK));
        do_rot      = !in_key && (pos_q == 3'd0);
        do_sub_only = (NK == 8) && !in_key && (pos_q == 3'd4);
        sub_word_in = prev_word;
        temp_word   = prev_word;
        if (do_rot) begin
            sub_word_in = {prev_word[WORD-BYTE-1:0], prev_word[WORD-1:WORD-BYTE]};
            temp_word   = sub_out ^ {rcon_q, {(WORD-BYTE){1'b0}}};
        end else if (do_sub_only) begin
            temp_word = sub_out;
        end
        word_now = in_key ? win_q[0] : (oldest_word ^ temp_word);
    end

    assign running = (state_q == ST_RUN);
    assign fire    = running && w_ready;
    assign w_valid = running;
    assign busy    = running;
    assign w_idx   = idx_q;
    assign done    = done_q;
    assign w_out   = running ? word_now : '0;
    assign sub_in  = running ? sub_word_in : '0;

    // Next-state logic: load the key on start, then advance one word per accept.
    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        idx_d   = idx_q;
        pos_d   = pos_q;
        rcon_d  = rcon_q;
        done_d  = 1'b0;
        if (state_q == ST_IDLE) begin
            if (start) begin
                for (int j = 0; j < NK; j++) begin
                    win_d[j] = key_in[255-WORD*j -: WORD];
                end
                idx_d   = '0;
                pos_d   = '0;
                rcon_d  = 8'h01;
                state_d = ST_RUN;
            end
        end else if (fire) begin
            for (int j = 0; j < NK - 1; j++) begin
                win_d[j] = win_q[j+1];
            end
            win_d[NK-1] = word_now;
            if (do_rot) begin
                rcon_d = {rcon_q[BYTE-2:0], 1'b0} ^ (rcon_q[BYTE-1] ? 8'h1b : 8'h00);
            end
            if (idx_q == 6'(TOTAL - 1)) begin
                state_d = ST_IDLE;
                idx_d   = '0;
                pos_d   = '0;
                done_d  = 1'b1;
            end else begin
                idx_d = idx_q + 6'd1;
                pos_d = (pos_q == 3'(NK - 1)) ? 3'd0 : pos_q + 3'd1;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            pos_q   <= '0;
            rcon_q  <= 8'h01;
            done_q  <= 1'b0;
            for (int j = 0; j < NK; j++) begin
                win_q[j] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pos_q   <= pos_d;
            rcon_q  <= rcon_d;
            done_q  <= done_d;
            for (int j = 0; j < NK; j++) begin
                win_q[j] <= win_d[j];
            end
        end
    end

endmodule

// File: tb/tb_aes_key_expander.sv
// Directed self-checking bench for aes_key_expander, with one instance each for NK=4/6/8.
module tb_aes_key_expander;

    localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [255:0] KC1  = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         start_s   [3];
    logic [255:0] key_s     [3];
    logic         ready_s   [3];
    logic [31:0]  wout_s    [3];
    logic [5:0]   widx_s    [3];
    logic         wvalid_s  [3];
    logic         busy_s    [3];
    logic         done_s    [3];
    logic [31:0]  sub_in_s  [3];
    logic [31:0]  sub_out_s [3];

    logic [31:0] exp_w [60];
    logic [31:0] cap_w [60];

    int total_checks = 0;
    int bad_checks   = 0;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        for (int n = 0; n < 8; n++) begin
            if (bb[0]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] p, r;
        p = a; r = 8'h01;
        for (int n = 0; n < 7; n++) begin
            p = gmul(p, p);
            r = gmul(r, p);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
    endfunction

    function automatic logic [7:0] rcon_of(input int n);
        case (n)
            1: return 8'h01;  2: return 8'h02;  3: return 8'h04;  4: return 8'h08;
            5: return 8'h10;  6: return 8'h20;  7: return 8'h40;  8: return 8'h80;
            9: return 8'h1b;  default: return 8'h36;
        endcase
    endfunction

    assign sub_out_s[0] = sub_word(sub_in_s[0]);
    assign sub_out_s[1] = sub_word(sub_in_s[1]);
    assign sub_out_s[2] = sub_word(sub_in_s[2]);

    aes_key_expander #(.NK(4)) u_nk4 (
        .clk(clk), .rst(rst), .start(start_s[0]), .key_in(key_s[0]),
        .w_out(wout_s[0]), .w_idx(widx_s[0]), .w_valid(wvalid_s[0]), .w_ready(ready_s[0]),
        .busy(busy_s[0]), .done(done_s[0]), .sub_in(sub_in_s[0]), .sub_out(sub_out_s[0]));

    aes_key_expander #(.NK(6)) u_nk6 (
        .clk(clk), .rst(rst), .start(start_s[1]), .key_in(key_s[1]),
        .w_out(wout_s[1]), .w_idx(widx_s[1]), .w_valid(wvalid_s[1]), .w_ready(ready_s[1]),
        .busy(busy_s[1]), .done(done_s[1]), .sub_in(sub_in_s[1]), .sub_out(sub_out_s[1]));

    aes_key_expander #(.NK(8)) u_nk8 (
        .clk(clk), .rst(rst), .start(start_s[2]), .key_in(key_s[2]),
        .w_out(wout_s[2]), .w_idx(widx_s[2]), .w_valid(wvalid_s[2]), .w_ready(ready_s[2]),
        .busy(busy_s[2]), .done(done_s[2]), .sub_in(sub_in_s[2]), .sub_out(sub_out_s[2]));

    // Textbook key schedule, using a table of round constants.
    task automatic build_expected(input int nk, input logic [255:0] key);
        logic [31:0] t;
        int total;
        total = 4 * (nk + 7);
        for (int i = 0; i < total; i++) begin
            if (i < nk) begin
                exp_w[i] = key[255-32*i -: 32];
            end else begin
                t = exp_w[i-1];
                if (i % nk == 0)
                    t = sub_word({t[23:0], t[31:24]}) ^ {rcon_of(i / nk), 24'h0};
                else if (nk > 6 && i % nk == 4)
                    t = sub_word(t);
                exp_w[i] = exp_w[i-nk] ^ t;
            end
        end
    endtask

    // Pulse start at the current negedge, then scramble key_in once start is accepted.
    task automatic kick(input int k, input logic [255:0] key);
        key_s[k]   = key;
        start_s[k] = 1'b1;
        @(negedge clk);
        start_s[k] = 1'b0;
        key_s[k]   = ~key;
        total_checks++;
        if (busy_s[k] !== 1'b1 || wvalid_s[k] !== 1'b1 || widx_s[k] !== 6'd0) begin
            bad_checks++;
            $display("[TB] FAIL kick_nk%0d: busy=%b valid=%b idx=%0d, want busy=1 valid=1 idx=0",
                     4 + 2 * k, busy_s[k], wvalid_s[k], widx_s[k]);
        end
    endtask

    // Consume one full expansion, checking each word, and end on the done cycle.
    task automatic stream(input int k, input bit rand_ready, input bit poke_start);
        int nk, total, got, cycles;
        bit r;
        logic [31:0] es;
        nk = 4 + 2 * k; total = 4 * (nk + 7); got = 0; cycles = 0;
        while (got < total && cycles < 1000) begin
            total_checks++;
            if (wvalid_s[k] !== 1'b1 || busy_s[k] !== 1'b1 || done_s[k] !== 1'b0) begin
                bad_checks++;
                $display("[TB] FAIL flags_nk%0d i=%0d: valid=%b busy=%b done=%b, want 1 1 0",
                         nk, got, wvalid_s[k], busy_s[k], done_s[k]);
            end
            total_checks++;
            if (widx_s[k] !== 6'(got)) begin
                bad_checks++;
                $display("[TB] FAIL w_idx_nk%0d: got %0d want %0d", nk, widx_s[k], got);
            end
            total_checks++;
            if (wout_s[k] !== exp_w[got]) begin
                bad_checks++;
                $display("[TB] FAIL w_out_nk%0d i=%0d: got %h want %h", nk, got, wout_s[k], exp_w[got]);
            end
            cap_w[got] = wout_s[k];
            if (got >= nk) begin
                es = exp_w[got-1];
                if (got % nk == 0) es = {es[23:0], es[31:24]};
                total_checks++;
                if (sub_in_s[k] !== es) begin
                    bad_checks++;
                    $display("[TB] FAIL sub_in_nk%0d i=%0d: got %h want %h", nk, got, sub_in_s[k], es);
                end
            end
            r = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            ready_s[k] = r;
            start_s[k] = poke_start && (got == 10);
            if (r) got++;
            @(negedge clk);
            cycles++;
        end
        ready_s[k] = 1'b0;
        start_s[k] = 1'b0;
        total_checks++;
        if (got < total) begin
            bad_checks++;
            $display("[TB] FAIL timeout_nk%0d: got %0d words want %0d", nk, got, total);
        end
        if (!rand_ready) begin
            total_checks++;
            if (cycles != total) begin
                bad_checks++;
                $display("[TB] FAIL throughput_nk%0d: took %0d cycles want %0d", nk, cycles, total);
            end
        end
        total_checks++;
        if (done_s[k] !== 1'b1 || busy_s[k] !== 1'b0 || wvalid_s[k] !== 1'b0 ||
            widx_s[k] !== 6'd0 || wout_s[k] !== 32'h0) begin
            bad_checks++;
            $display("[TB] FAIL done_cycle_nk%0d: done=%b busy=%b valid=%b idx=%0d w=%h, want 1 0 0 0 0",
                     nk, done_s[k], busy_s[k], wvalid_s[k], widx_s[k], wout_s[k]);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            start_s[k] = 1'b0; ready_s[k] = 1'b0; key_s[k] = '0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            total_checks++;
            if (busy_s[k] !== 1'b0 || wvalid_s[k] !== 1'b0 || done_s[k] !== 1'b0 ||
                wout_s[k] !== 32'h0 || widx_s[k] !== 6'd0 || sub_in_s[k] !== 32'h0) begin
                bad_checks++;
                $display("[TB] FAIL reset_nk%0d: busy=%b valid=%b done=%b w=%h idx=%0d sub=%h, want all 0",
                         4 + 2 * k, busy_s[k], wvalid_s[k], done_s[k], wout_s[k], widx_s[k], sub_in_s[k]);
            end
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_nk4;
        build_expected(4, K128);
        kick(0, K128);
        stream(0, 1'b0, 1'b0);
        total_checks++;
        if (cap_w[4] !== 32'ha0fafe17) begin
            bad_checks++; $display("[TB] FAIL nk4_w4: got %h want a0fafe17", cap_w[4]);
        end
        total_checks++;
        if (cap_w[43] !== 32'hb6630ca6) begin
            bad_checks++; $display("[TB] FAIL nk4_w43: got %h want b6630ca6", cap_w[43]);
        end
        @(negedge clk);
        total_checks++;
        if (done_s[0] !== 1'b0) begin
            bad_checks++; $display("[TB] FAIL nk4_done_width: done=%b want 0", done_s[0]);
        end
    endtask

    task automatic test_nk6;
        build_expected(6, K192);
        kick(1, K192);
        stream(1, 1'b0, 1'b0);
        total_checks++;
        if (cap_w[6] !== 32'hfe0c91f7) begin
            bad_checks++; $display("[TB] FAIL nk6_w6: got %h want fe0c91f7", cap_w[6]);
        end
        total_checks++;
        if (cap_w[51] !== 32'h01002202) begin
            bad_checks++; $display("[TB] FAIL nk6_w51: got %h want 01002202", cap_w[51]);
        end
        @(negedge clk);
    endtask

    task automatic test_nk8;
        build_expected(8, K256);
        kick(2, K256);
        stream(2, 1'b0, 1'b0);
        total_checks++;
        if (cap_w[8] !== 32'h9ba35411) begin
            bad_checks++; $display("[TB] FAIL nk8_w8: got %h want 9ba35411", cap_w[8]);
        end
        total_checks++;
        if (cap_w[59] !== 32'h706c631e) begin
            bad_checks++; $display("[TB] FAIL nk8_w59: got %h want 706c631e", cap_w[59]);
        end
        @(negedge clk);
    endtask

    task automatic test_stall_and_start;
        build_expected(4, K128);
        kick(0, K128);
        stream(0, 1'b1, 1'b1);
        @(negedge clk);
        total_checks++;
        if (done_s[0] !== 1'b0 || busy_s[0] !== 1'b0) begin
            bad_checks++;
            $display("[TB] FAIL stall_after_done: done=%b busy=%b want 0 0", done_s[0], busy_s[0]);
        end
    endtask

    task automatic test_reset_mid;
        int n;
        build_expected(4, K128);
        kick(0, K128);
        ready_s[0] = 1'b1;
        n = 0;
        while (widx_s[0] !== 6'd20 && n < 100) begin
            @(negedge clk);
            n++;
        end
        total_checks++;
        if (n >= 100) begin
            bad_checks++; $display("[TB] FAIL mid_reset_reach: idx=%0d want 20", widx_s[0]);
        end
        rst = 1'b1;
        ready_s[0] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        total_checks++;
        if (wvalid_s[0] !== 1'b0 || busy_s[0] !== 1'b0 || done_s[0] !== 1'b0 ||
            widx_s[0] !== 6'd0 || wout_s[0] !== 32'h0) begin
            bad_checks++;
            $display("[TB] FAIL mid_reset_state: valid=%b busy=%b done=%b idx=%0d w=%h, want all 0",
                     wvalid_s[0], busy_s[0], done_s[0], widx_s[0], wout_s[0]);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total_checks++;
            if (done_s[0] !== 1'b0 || wvalid_s[0] !== 1'b0) begin
                bad_checks++;
                $display("[TB] FAIL mid_reset_quiet: done=%b valid=%b want 0 0", done_s[0], wvalid_s[0]);
            end
        end
        kick(0, K128);
        stream(0, 1'b0, 1'b0);
        total_checks++;
        if (cap_w[4] !== 32'ha0fafe17) begin
            bad_checks++; $display("[TB] FAIL mid_reset_restart_w4: got %h want a0fafe17", cap_w[4]);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        build_expected(4, K128);
        kick(0, K128);
        stream(0, 1'b0, 1'b0);
        build_expected(4, KC1);
        kick(0, KC1);
        stream(0, 1'b0, 1'b0);
        total_checks++;
        if (cap_w[4] !== 32'hd6aa74fd) begin
            bad_checks++; $display("[TB] FAIL b2b_w4: got %h want d6aa74fd", cap_w[4]);
        end
        total_checks++;
        if (cap_w[43] !== 32'h4d2b30c5) begin
            bad_checks++; $display("[TB] FAIL b2b_w43: got %h want 4d2b30c5", cap_w[43]);
        end
        @(negedge clk);
    endtask

    initial begin
        $display("[TB] aes_key_expander bench starting");
        test_reset();
        test_nk4();
        test_nk6();
        test_nk8();
        test_stall_and_start();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule
